// File: rtl/nibble_pair_loader.sv
// Captures two nibbles from a shared switch bus on rising load edges and presents
// the pair {In1, In0} downstream with a valid/ready handshake.
module nibble_pair_loader #(
   parameter int unsigned CNT_W    = 8,
   parameter bit          LO_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       nib_in,
   input  logic             load,
   input  logic             flush,
   input  logic             out_ready,
   output logic [3:0]       In0,
   output logic [3:0]       In1,
   output logic             out_valid,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] pair_cnt,
   output logic             overrun
);

   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StHalf  = 2'b01,
      StFull  = 2'b10
   } st_e;

   st_e              state_q, state_d;
   logic [3:0]       in0_q, in0_d;
   logic [3:0]       in1_q, in1_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
   logic             load_q;
   logic             ld_edge;

   // load_q resets high so a strobe held through reset release is not an edge
   assign ld_edge = load & ~load_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StEmpty;
         in0_q     <= 4'h0;
         in1_q     <= 4'h0;
         valid_q   <= 1'b0;
         cnt_q     <= '0;
         overrun_q <= 1'b0;
         load_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         in0_q     <= in0_d;
         in1_q     <= in1_d;
         valid_q   <= valid_d;
         cnt_q     <= cnt_d;
         overrun_q <= overrun_d;
         load_q    <= load;
      end
   end

   always_comb begin
      state_d   = state_q;
      in0_d     = in0_q;
      in1_d     = in1_q;
      cnt_d     = cnt_q;
      overrun_d = overrun_q;

      if (flush) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (ld_edge) begin
                  if (LO_FIRST) in0_d = nib_in;
                  else          in1_d = nib_in;
                  state_d = StHalf;
               end
            end
            StHalf: begin
               if (ld_edge) begin
                  if (LO_FIRST) in1_d = nib_in;
                  else          in0_d = nib_in;
                  state_d = StFull;
               end
            end
            StFull: begin
               // A load edge while full is dropped, even alongside a transfer
               if (ld_edge) overrun_d = 1'b1;
               if (valid_q && out_ready) begin
                  cnt_d   = cnt_q + CNT_W'(1);
                  state_d = StEmpty;
               end
            end
            default: state_d = StEmpty;
         endcase
      end

      valid_d = (state_d == StFull);
   end

   assign In0       = in0_q;
   assign In1       = in1_q;
   assign out_valid = valid_q;
   assign state     = state_q;
   assign pair_cnt  = cnt_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_nibble_pair_loader.sv
// Directed bench for nibble_pair_loader: a default instance (a) and a LO_FIRST=0,
// CNT_W=2 instance (b) driven by the same stimulus.
module tb_nibble_pair_loader;

   logic       clk = 1'b0;
   logic       rst, load, flush, out_ready;
   logic [3:0] nib_in;

   logic [3:0] a_in0, a_in1, b_in0, b_in1;
   logic       a_valid, b_valid, a_ovr, b_ovr;
   logic [1:0] a_state, b_state;
   logic [7:0] a_cnt;
   logic [1:0] b_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   nibble_pair_loader u_a (
      .clk(clk), .rst(rst), .nib_in(nib_in), .load(load), .flush(flush),
      .out_ready(out_ready), .In0(a_in0), .In1(a_in1), .out_valid(a_valid),
      .state(a_state), .pair_cnt(a_cnt), .overrun(a_ovr)
   );

   nibble_pair_loader #(.CNT_W(2), .LO_FIRST(1'b0)) u_b (
      .clk(clk), .rst(rst), .nib_in(nib_in), .load(load), .flush(flush),
      .out_ready(out_ready), .In0(b_in0), .In1(b_in1), .out_valid(b_valid),
      .state(b_state), .pair_cnt(b_cnt), .overrun(b_ovr)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_load(input logic [3:0] nib);
      nib_in = nib;
      load   = 1'b1;
      tick();
      load   = 1'b0;
      tick();
   endtask

   task automatic transfer();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; flush = 1'b0; out_ready = 1'b0; nib_in = 4'h0;
      #12;
      check("rst_a_state", a_state, 8'h0);
      check("rst_a_nibs", {a_in1, a_in0}, 8'h00);
      check("rst_a_valid", a_valid, 8'h0);
      check("rst_a_cnt", a_cnt, 8'h0);
      check("rst_a_ovr", a_ovr, 8'h0);
      check("rst_b_cnt", b_cnt, 8'h0);
      rst = 1'b0;
      tick();

      // 1) basic pair and transfer
      nib_in = 4'hA; load = 1'b1;
      tick();
      check("t1_a_half", a_state, 8'h1);
      check("t1_a_in0_first", a_in0, 8'hA);
      check("t1_b_in1_first", b_in1, 8'hA);
      load = 1'b0;
      tick();
      pulse_load(4'h5);
      check("t1_a_dout", {a_in1, a_in0}, 8'h5A);
      check("t1_a_valid", a_valid, 8'h1);
      check("t1_a_full", a_state, 8'h2);
      check("t1_b_dout", {b_in1, b_in0}, 8'hA5);
      transfer();
      check("t1_a_valid_drop", a_valid, 8'h0);
      check("t1_a_cnt", a_cnt, 8'h1);
      check("t1_a_empty", a_state, 8'h0);
      check("t1_b_cnt", b_cnt, 8'h1);

      // 2) order and stall stability
      pulse_load(4'h3);
      pulse_load(4'hC);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2_b_hold_dout", {b_in1, b_in0}, 8'h3C);
         check("t2_b_hold_valid", b_valid, 8'h1);
      end
      check("t2_a_dout", {a_in1, a_in0}, 8'hC3);

      // 3) overrun while full
      pulse_load(4'hF);
      check("t3_a_dout_frozen", {a_in1, a_in0}, 8'hC3);
      check("t3_a_ovr", a_ovr, 8'h1);
      check("t3_a_still_full", a_state, 8'h2);
      transfer();
      check("t3_a_cnt", a_cnt, 8'h2);
      pulse_load(4'h1);
      pulse_load(4'h2);
      check("t3_a_new_dout", {a_in1, a_in0}, 8'h21);
      check("t3_b_new_dout", {b_in1, b_in0}, 8'h12);
      check("t3_a_ovr_sticky", a_ovr, 8'h1);
      transfer();
      check("t3_a_cnt2", a_cnt, 8'h3);
      check("t3_b_cnt2", b_cnt, 8'h3);

      // 4) load held high across reset release
      load = 1'b1;
      rst  = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      tick();
      check("t4_a_empty", a_state, 8'h0);
      check("t4_a_ovr_cleared", a_ovr, 8'h0);
      check("t4_a_cnt_lost", a_cnt, 8'h0);
      load = 1'b0;
      tick();
      nib_in = 4'h7; load = 1'b1;
      tick();
      check("t4_a_half", a_state, 8'h1);
      load = 1'b0;
      tick();
      pulse_load(4'h8);
      transfer();
      check("t4_a_cnt", a_cnt, 8'h1);

      // 5) flush in HALF with a load edge, then flush in FULL against a transfer
      pulse_load(4'h7);
      nib_in = 4'h9; load = 1'b1; flush = 1'b1;
      tick();
      flush = 1'b0;
      check("t5_a_empty", a_state, 8'h0);
      check("t5_a_ovr", a_ovr, 8'h0);
      check("t5_a_cnt", a_cnt, 8'h1);
      check("t5_a_nibs", {a_in1, a_in0}, 8'h87);
      load = 1'b0;
      tick();
      pulse_load(4'h4);
      pulse_load(4'h6);
      check("t5_a_valid_pre", a_valid, 8'h1);
      flush = 1'b1; out_ready = 1'b1;
      tick();
      flush = 1'b0; out_ready = 1'b0;
      check("t5_a_flush_valid", a_valid, 8'h0);
      check("t5_a_flush_state", a_state, 8'h0);
      check("t5_a_flush_cnt", a_cnt, 8'h1);
      check("t5_a_flush_nibs", {a_in1, a_in0}, 8'h64);

      // 6) counter wrap and asynchronous reset in HALF
      pulse_load(4'h1); pulse_load(4'h2); transfer();
      check("t6_b_cnt2", b_cnt, 8'h2);
      pulse_load(4'h3); pulse_load(4'h4); transfer();
      check("t6_b_cnt3", b_cnt, 8'h3);
      pulse_load(4'h5); pulse_load(4'h6); transfer();
      check("t6_b_cnt_wrap", b_cnt, 8'h0);
      check("t6_a_cnt4", a_cnt, 8'h4);
      pulse_load(4'hE);
      check("t6_a_half", a_state, 8'h1);
      rst = 1'b1;
      #2;
      check("t6_async_state", a_state, 8'h0);
      check("t6_async_nibs", {a_in1, a_in0}, 8'h00);
      check("t6_async_cnt", a_cnt, 8'h0);
      check("t6_async_valid", a_valid, 8'h0);
      check("t6_async_b_nibs", {b_in1, b_in0}, 8'h00);
      check("t6_async_ovr", a_ovr, 8'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
